// File: rtl/spi_slave.sv
// spi_slave: oversampled SPI target, full-duplex MSB first; SPI_MISO_TRISTATE_EN floats MISO while deselected
module spi_slave #(
  parameter int SPI_MODE = 0
) (
  input  logic       i_Clk,
  input  logic       i_Rst,
  output logic       o_RX_DV,
  output logic [7:0] o_RX_Byte,
  input  logic       i_TX_DV,
  input  logic [7:0] i_TX_Byte,
  input  logic       i_SPI_Clk,
  output logic       o_SPI_MISO,
  input  logic       i_SPI_MOSI,
  input  logic       i_SPI_CS_n
);
  localparam bit CPOL = SPI_MODE[1];
  localparam bit CPHA = SPI_MODE[0];
  logic [1:0] sclk_s, cs_s, mosi_s;
  logic       sclk_d, cs_n, lead, trail, samp, shft, miso;
  logic [2:0] cnt;
  logic [6:0] rx_sr;
  logic [7:0] hold, hold_next, tx_sr;
  assign cs_n      = cs_s[1];
  assign lead      = !cs_n && sclk_d == CPOL && sclk_s[1] != CPOL;
  assign trail     = !cs_n && sclk_d != CPOL && sclk_s[1] == CPOL;
  assign samp      = CPHA ? trail : lead;
  assign shft      = CPHA ? lead : trail;
  assign hold_next = i_TX_DV ? i_TX_Byte : hold;
  assign miso      = (cs_n || (!CPHA && cnt == 3'd0)) ? hold[7] : tx_sr[7];
`ifdef SPI_MISO_TRISTATE_EN
  assign o_SPI_MISO = (cs_n || i_Rst) ? 1'bz : miso;
`else
  assign o_SPI_MISO = miso;
`endif
  // two-flop synchronizers for the asynchronous SPI pins plus a delayed SCLK for edge detection
  always_ff @(posedge i_Clk or posedge i_Rst)
    if (i_Rst) begin
      sclk_s <= {2{CPOL}};
      sclk_d <= CPOL;
      cs_s   <= 2'b11;
      mosi_s <= 2'b00;
    end else begin
      sclk_s <= {sclk_s[0], i_SPI_Clk};
      sclk_d <= sclk_s[1];
      cs_s   <= {cs_s[0], i_SPI_CS_n};
      mosi_s <= {mosi_s[0], i_SPI_MOSI};
    end
  // receive path: shift on sampling edges, publish the byte and strobe on the eighth sample
  always_ff @(posedge i_Clk or posedge i_Rst)
    if (i_Rst) begin
      cnt       <= 3'd0;
      rx_sr     <= 7'd0;
      o_RX_Byte <= 8'd0;
      o_RX_DV   <= 1'b0;
    end else begin
      o_RX_DV <= 1'b0;
      if (cs_n) cnt <= 3'd0;
      else if (samp) begin
        rx_sr <= {rx_sr[5:0], mosi_s[1]};
        cnt   <= cnt + 3'd1;
        if (cnt == 3'd7) begin
          o_RX_Byte <= {rx_sr, mosi_s[1]};
          o_RX_DV   <= 1'b1;
        end
      end
    end
  // transmit path: holding register reloads on strobe, copied into the shifter at each byte's first edge
  always_ff @(posedge i_Clk or posedge i_Rst)
    if (i_Rst) begin
      hold  <= 8'd0;
      tx_sr <= 8'd0;
    end else begin
      hold <= hold_next;
      if (lead && cnt == 3'd0) tx_sr <= hold_next;
      else if (shft) tx_sr <= {tx_sr[6:0], 1'b0};
    end
endmodule

// File: tb/tb_spi_slave.sv
// tb_spi_slave: directed checks of spi_slave in mode 0 (dut 0) and mode 3 (dut 1)
module tb_spi_slave;
  localparam int HALF = 80;
  logic clk = 0, rst = 1;
  logic sclk [2], mosi [2], cs_n [2], miso [2], tx_dv [2], rx_dv [2];
  logic [7:0] tx_byte [2], rx_byte [2];
  int dv_cnt [2];
  int checks = 0, failures = 0;
  always #5 clk = ~clk;
  spi_slave #(.SPI_MODE(0)) u0 (.i_Clk(clk), .i_Rst(rst), .o_RX_DV(rx_dv[0]), .o_RX_Byte(rx_byte[0]),
    .i_TX_DV(tx_dv[0]), .i_TX_Byte(tx_byte[0]), .i_SPI_Clk(sclk[0]), .o_SPI_MISO(miso[0]),
    .i_SPI_MOSI(mosi[0]), .i_SPI_CS_n(cs_n[0]));
  spi_slave #(.SPI_MODE(3)) u1 (.i_Clk(clk), .i_Rst(rst), .o_RX_DV(rx_dv[1]), .o_RX_Byte(rx_byte[1]),
    .i_TX_DV(tx_dv[1]), .i_TX_Byte(tx_byte[1]), .i_SPI_Clk(sclk[1]), .o_SPI_MISO(miso[1]),
    .i_SPI_MOSI(mosi[1]), .i_SPI_CS_n(cs_n[1]));
  // count strobe-high cycles; a pulse wider than one cycle shows up as an extra count
  always @(negedge clk) for (int m = 0; m < 2; m++) if (rx_dv[m]) dv_cnt[m] <= dv_cnt[m] + 1;
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
    $fatal(1, "watchdog");
  end
  task automatic load(input int m, input logic [7:0] b);
    @(negedge clk);
    tx_dv[m] = 1; tx_byte[m] = b;
    @(negedge clk);
    tx_dv[m] = 0;
  endtask
  task automatic cs_lo(input int m);
    @(negedge clk);
    cs_n[m] = 0;
    #HALF;
  endtask
  task automatic cs_hi(input int m);
    #HALF;
    cs_n[m] = 1;
    #(HALF * 2);
  endtask
  task automatic xfer(input int m, input logic [7:0] tx, output logic [7:0] rx, input int n);
    rx = 0;
    for (int i = 7; i >= 8 - n; i--) begin
      if (m == 0) begin
        mosi[m] = tx[i]; #HALF;
        rx = {rx[6:0], miso[m]}; sclk[m] = 1; #HALF;
        sclk[m] = 0;
      end else begin
        sclk[m] = 0; mosi[m] = tx[i]; #HALF;
        rx = {rx[6:0], miso[m]}; sclk[m] = 1; #HALF;
      end
    end
  endtask
  task automatic chk8(input string name, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %02h want %02h", name, got, exp);
    end
  endtask
  task automatic test_reset;
    logic idle;
`ifdef SPI_MISO_TRISTATE_EN
    idle = 1'bz;
`else
    idle = 1'b0;
`endif
    #3;
    for (int m = 0; m < 2; m++) begin
      checks++; if (rx_dv[m] !== 1'b0) begin failures++; $display("FAIL reset_dv%0d: got %b want 0", m, rx_dv[m]); end
      checks++; if (rx_byte[m] !== 8'h00) begin failures++; $display("FAIL reset_byte%0d: got %02h want 00", m, rx_byte[m]); end
    end
    repeat (3) @(negedge clk);
    rst = 0;
    repeat (3) @(negedge clk);
    checks++; if (miso[0] !== idle) begin failures++; $display("FAIL reset_miso: got %b want %b", miso[0], idle); end
  endtask
  task automatic test_basic;
    logic [7:0] r;
    int b = dv_cnt[0];
    load(0, 8'h3C); cs_lo(0); xfer(0, 8'hAA, r, 8); cs_hi(0);
    chk8("basic_miso", r, 8'h3C);
    chk8("basic_rx", rx_byte[0], 8'hAA);
    chk8("basic_dvcnt", 8'(dv_cnt[0] - b), 8'd1);
  endtask
  task automatic test_back_to_back;
    logic [7:0] r1, r2;
    int b = dv_cnt[0];
    load(0, 8'hA5); cs_lo(0);
    fork
      begin xfer(0, 8'h77, r1, 8); xfer(0, 8'h00, r2, 8); end
      begin
        for (int k = 0; k < 400 && dv_cnt[0] == b; k++) @(negedge clk);
        checks++;
        if (dv_cnt[0] == b) begin failures++; $display("FAIL b2b_wait: got no strobe want strobe"); end
        else begin
          chk8("b2b_first_rx", rx_byte[0], 8'h77);
          load(0, 8'h05);
        end
      end
    join
    cs_hi(0);
    chk8("b2b_miso1", r1, 8'hA5);
    chk8("b2b_miso2", r2, 8'h05);
    chk8("b2b_rx2", rx_byte[0], 8'h00);
    chk8("b2b_dvcnt", 8'(dv_cnt[0] - b), 8'd2);
  endtask
  task automatic test_cs_abort;
    logic [7:0] r;
    int b = dv_cnt[0];
    cs_lo(0); xfer(0, 8'hFF, r, 5); cs_hi(0);
    chk8("abort_nodv", 8'(dv_cnt[0] - b), 8'd0);
    chk8("abort_keep", rx_byte[0], 8'h00);
    cs_lo(0); xfer(0, 8'h66, r, 8); cs_hi(0);
    chk8("abort_rx", rx_byte[0], 8'h66);
    chk8("abort_dvcnt", 8'(dv_cnt[0] - b), 8'd1);
  endtask
  task automatic test_repeat;
    logic [7:0] r;
    logic [7:0] pat [3] = '{8'h12, 8'h34, 8'h56};
    int b = dv_cnt[0];
    load(0, 8'h5A); cs_lo(0);
    for (int i = 0; i < 3; i++) begin
      xfer(0, pat[i], r, 8);
      chk8("repeat_miso", r, 8'h5A);
    end
    cs_hi(0);
    chk8("repeat_rx", rx_byte[0], 8'h56);
    chk8("repeat_dvcnt", 8'(dv_cnt[0] - b), 8'd3);
  endtask
  task automatic test_mode3;
    logic [7:0] r;
    int b = dv_cnt[1];
    load(1, 8'hC3); cs_lo(1); xfer(1, 8'h99, r, 8); cs_hi(1);
    chk8("mode3_miso", r, 8'hC3);
    chk8("mode3_rx", rx_byte[1], 8'h99);
    chk8("mode3_dvcnt", 8'(dv_cnt[1] - b), 8'd1);
  endtask
  task automatic test_reset_mid;
    logic [7:0] r;
    logic idle;
    int b;
    load(0, 8'h11); cs_lo(0); xfer(0, 8'hF0, r, 4);
    #3 rst = 1;
    #1;
    checks++; if (rx_dv[0] !== 1'b0) begin failures++; $display("FAIL rstmid_dv: got %b want 0", rx_dv[0]); end
    chk8("rstmid_byte", rx_byte[0], 8'h00);
`ifdef SPI_MISO_TRISTATE_EN
    checks++; if (miso[0] !== 1'bz) begin failures++; $display("FAIL rstmid_z: got %b want z", miso[0]); end
`endif
    repeat (3) @(negedge clk);
    rst = 0;
    cs_hi(0);
    b = dv_cnt[0];
    load(0, 8'h81); cs_lo(0); xfer(0, 8'h55, r, 8); cs_hi(0);
    chk8("rstmid_rx", rx_byte[0], 8'h55);
    chk8("rstmid_miso", r, 8'h81);
    chk8("rstmid_dvcnt", 8'(dv_cnt[0] - b), 8'd1);
`ifdef SPI_MISO_TRISTATE_EN
    idle = 1'bz;
`else
    idle = 1'b1;
`endif
    checks++; if (miso[0] !== idle) begin failures++; $display("FAIL idle_miso: got %b want %b", miso[0], idle); end
  endtask
  initial begin
    for (int m = 0; m < 2; m++) begin
      sclk[m] = (m == 1); mosi[m] = 0; cs_n[m] = 1; tx_dv[m] = 0; tx_byte[m] = 0; dv_cnt[m] = 0;
    end
    test_reset;
    test_basic;
    test_back_to_back;
    test_cs_abort;
    test_repeat;
    test_mode3;
    test_reset_mid;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/spi_slave.md
Name: spi_slave

Overview:
- SPI target (slave) interface for the ROMulator diagnostics controller.
- Oversamples an external SPI bus in the system clock domain and delivers each received byte as a one-cycle strobe.
- Shifts out a byte that the controller has preloaded, full-duplex, MSB first.
- A single clock domain: the SPI lines are treated as asynchronous inputs.

Parameters:
- SPI_MODE, 0, SPI mode 0..3: CPOL = SPI_MODE[1], CPHA = SPI_MODE[0].

Ports:
- i_Clk  input  1  system clock; the only clock in the block.
- i_Rst  input  1  asynchronous, active-high reset.
- o_RX_DV  output  1  one-cycle strobe: o_RX_Byte holds a newly completed byte.
- o_RX_Byte  output  8  last received byte; held until the next byte completes.
- i_TX_DV  input  1  one-cycle load strobe for i_TX_Byte.
- i_TX_Byte  input  8  byte to transmit in the next SPI byte frame.
- i_SPI_Clk  input  1  SPI SCLK, asynchronous.
- o_SPI_MISO  output  1  SPI data out.
- i_SPI_MOSI  input  1  SPI data in, asynchronous.
- i_SPI_CS_n  input  1  SPI chip select, active low, asynchronous.

Behaviour:
- Reset values: o_RX_DV=0, o_RX_Byte=0x00, TX holding register=0x00, bit counter=0. Synchronizers reset to idle: SCLK=CPOL, CS_n=1.
- Synchronization: SCLK, MOSI and CS_n each pass through a 2-FF synchronizer.
- Edge detection uses the synchronized SCLK and its delayed copy.
- Clock ratio: i_Clk must run at ≥8× SCLK. Behaviour at lower ratios is undefined.
- Edges: leading edge = the transition away from CPOL. Sampling edge = leading edge if CPHA=0, trailing edge if CPHA=1. The shift edge is the other edge.
- Edges are honoured only while the synchronized CS_n is low.
- RX:
  - On each sampling edge, shift MOSI into the RX shift register, MSB first, and increment the 3-bit counter.
  - On the 8th sample (counter wraps 7→0), on the next i_Clk: load o_RX_Byte and pulse o_RX_DV high for exactly one cycle.
  - Latency from the SCLK pin edge to o_RX_DV is ≤4 i_Clk cycles.
- TX holding register:
  - Loaded from i_TX_Byte on any cycle with i_TX_DV=1, regardless of CS_n.
  - Retains its value; if not reloaded, the same byte is repeated in every frame.
- TX frame:
  - At the first SCLK edge of each byte (counter==0), the holding register is copied into the TX shift register.
  - A load strobe arriving after that edge applies to the following byte.
  - If i_TX_DV and the frame-start copy coincide, the new i_TX_Byte is used.
- MISO, CPHA=0: while counter==0, MISO = holding[7]. Otherwise MISO = next shift-register bit, advanced on each shift edge. MSB is valid before the first sampling edge.
- MISO, CPHA=1: MISO updates on each shift (leading) edge, starting with bit 7 at the first leading edge.
- CS_n deassert (synchronized high):
  - Counter resets to 0 and a partial byte is discarded; no o_RX_DV.
  - o_RX_Byte is unchanged; the holding register is kept.
- Reset mid-frame: all state returns to reset values immediately (asynchronous). The frame is lost.
- Simultaneous CS_n rise and 8th sampling edge in the same cycle: CS_n wins, no o_RX_DV.

Optional Feature:
- Macro: SPI_MISO_TRISTATE_EN.
- Defined: o_SPI_MISO = high-Z whenever synchronized CS_n is high or i_Rst is asserted.
- Undefined: o_SPI_MISO is always driven and outputs holding[7] while CS_n is high.

Test Plan:
- Mode 0, TX preloaded 0x3C, master sends 0xAA: one o_RX_DV pulse with o_RX_Byte=0xAA; master receives 0x3C.
- Two-byte frame, master sends 0x77 then 0x00; on the o_RX_DV for 0x77, strobe i_TX_Byte=0x05: master receives holding byte then 0x05. Second strobe reports 0x00.
- CS_n raised after 5 bits, then a full byte 0x66: no strobe for the partial byte; next strobe reports 0x66, not a shifted mix.
- Repeat without reload, holding=0x5A, three bytes sent: master reads 0x5A three times.
- SPI_MODE=3 (CPOL=1, CPHA=1), master sends 0x99, TX=0xC3: o_RX_Byte=0x99, master reads 0xC3.
- i_Rst asserted mid-byte: o_RX_DV=0, o_RX_Byte=0x00 immediately; next full byte 0x55 is received correctly. With SPI_MISO_TRISTATE_EN defined, MISO is Z while CS_n is high.
